// File: rtl/wordle_pkg.sv
// wordle_pkg: shared key codes, score encodings and one-hot state values for the guess entry block
package wordle_pkg;
    localparam int WORD_LEN = 5;

    localparam logic [4:0] KEY_A     = 5'd0;
    localparam logic [4:0] KEY_Z     = 5'd25;
    localparam logic [4:0] KEY_DEL   = 5'd26;
    localparam logic [4:0] KEY_ENTER = 5'd27;

    localparam logic [1:0] SCORE_GRAY   = 2'b00;
    localparam logic [1:0] SCORE_YELLOW = 2'b01;
    localparam logic [1:0] SCORE_GREEN  = 2'b10;

    localparam logic [4:0] ST_I      = 5'b00001;
    localparam logic [4:0] ST_ENTRY  = 5'b00010;
    localparam logic [4:0] ST_GREEN  = 5'b00100;
    localparam logic [4:0] ST_YELLOW = 5'b01000;
    localparam logic [4:0] ST_DONE   = 5'b10000;

    typedef enum logic [4:0] {
        QI      = ST_I,
        QENTRY  = ST_ENTRY,
        QGREEN  = ST_GREEN,
        QYELLOW = ST_YELLOW,
        QDONE   = ST_DONE
    } state_t;
endpackage

// File: rtl/wordle_yellow_match.sv
// wordle_yellow_match: finds the lowest unused target position holding a given letter
module wordle_yellow_match
    import wordle_pkg::*;
(
    input  logic [4:0]            letter,
    input  logic [5*WORD_LEN-1:0] target,
    input  logic [WORD_LEN-1:0]   used,
    output logic                  hit,
    output logic [WORD_LEN-1:0]   match_j
);
    logic [WORD_LEN-1:0] cand;

    always_comb begin
        cand = '0;
        for (int j = 0; j < WORD_LEN; j++)
            cand[j] = !used[j] && target[5*j +: 5] == letter;
    end

    // isolate the lowest set bit so duplicates consume target letters left to right
    assign match_j = cand & (~cand + 1'b1);
    assign hit     = |cand;
endmodule

// File: rtl/wordle_guess_entry.sv
// wordle_guess_entry: assembles a guess from key strobes and scores it against the target word
module wordle_guess_entry
    import wordle_pkg::*;
#(
    parameter int MAX_GUESSES = 6
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic [24:0] target,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        q_I,
    output logic        q_Entry,
    output logic        q_Score,
    output logic        q_Done,
    output logic [24:0] guess,
    output logic [2:0]  guess_len,
    output logic [9:0]  score,
    output logic        win,
    output logic [2:0]  guess_num,
    output logic        game_over
);
    state_t              state;
    logic [24:0]         tgt;
    logic [WORD_LEN-1:0] used;
    logic [2:0]          idx;
    logic [WORD_LEN-1:0] green;
    logic [9:0]          score_g;
    logic [4:0]          cur;
    logic [1:0]          cur_score;
    logic                hit;
    logic [WORD_LEN-1:0] match_j;

    assign q_I     = state == QI;
    assign q_Entry = state == QENTRY;
    assign q_Score = state == QGREEN || state == QYELLOW;
    assign q_Done  = state == QDONE;

    always_comb begin
        green   = '0;
        score_g = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            green[i]          = guess[5*i +: 5] == tgt[5*i +: 5];
            score_g[2*i +: 2] = green[i] ? SCORE_GREEN : SCORE_GRAY;
        end
        cur       = guess[5*int'(idx) +: 5];
        cur_score = score[2*int'(idx) +: 2];
    end

    wordle_yellow_match u_match (
        .letter  (cur),
        .target  (tgt),
        .used    (used),
        .hit     (hit),
        .match_j (match_j)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= QI;
            tgt       <= '0;
            used      <= '0;
            idx       <= '0;
            guess     <= '0;
            guess_len <= '0;
            score     <= '0;
            win       <= 1'b0;
            guess_num <= '0;
            game_over <= 1'b0;
        end else begin
            case (state)
                QI: if (Start) begin
                    tgt       <= target;
                    guess     <= '0;
                    guess_len <= '0;
                    guess_num <= '0;
                    win       <= 1'b0;
                    score     <= '0;
                    game_over <= 1'b0;
                    state     <= QENTRY;
                end
                QENTRY: if (key_valid) begin
                    if (key_code <= KEY_Z && guess_len < 3'(WORD_LEN)) begin
                        guess[5*int'(guess_len) +: 5] <= key_code;
                        guess_len <= guess_len + 3'd1;
                    end else if (key_code == KEY_DEL && guess_len != 3'd0) begin
                        guess[5*(int'(guess_len) - 1) +: 5] <= '0;
                        guess_len <= guess_len - 3'd1;
                    end else if (key_code == KEY_ENTER && guess_len == 3'(WORD_LEN)) begin
                        state <= QGREEN;
                    end
                end
                QGREEN: begin
                    score <= score_g;
                    used  <= green;
                    idx   <= '0;
                    state <= QYELLOW;
                end
                QYELLOW: begin
                    if (cur_score != SCORE_GREEN && hit) begin
                        score[2*int'(idx) +: 2] <= SCORE_YELLOW;
                        used <= used | match_j;
                    end
                    if (idx == 3'(WORD_LEN - 1)) begin
                        win       <= &green;
                        guess_num <= guess_num + 3'd1;
                        state     <= QDONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                QDONE: if (Ack) begin
                    // a finished game keeps its last guess and score on display
                    if (win || guess_num == 3'(MAX_GUESSES)) begin
                        game_over <= 1'b1;
                        state     <= QI;
                    end else begin
                        guess     <= '0;
                        guess_len <= '0;
                        score     <= '0;
                        state     <= QENTRY;
                    end
                end
                default: state <= QI;
            endcase
        end
    end
endmodule

// File: tb/tb_wordle_guess_entry.sv
// tb_wordle_guess_entry: table-driven entry checks plus directed scoring, exhaustion and reset sequences
module tb_wordle_guess_entry;
    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        Ack = 1'b0;
    logic [24:0] target = '0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic        q_I, q_Entry, q_Score, q_Done;
    logic [24:0] guess;
    logic [2:0]  guess_len;
    logic [9:0]  score;
    logic        win;
    logic [2:0]  guess_num;
    logic        game_over;

    int passed = 0;
    int total = 0;

    wordle_guess_entry #(.MAX_GUESSES(6)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .target(target),
        .key_valid(key_valid), .key_code(key_code),
        .q_I(q_I), .q_Entry(q_Entry), .q_Score(q_Score), .q_Done(q_Done),
        .guess(guess), .guess_len(guess_len), .score(score), .win(win),
        .guess_num(guess_num), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  code;
        logic [2:0]  len;
        logic [24:0] g;
        logic        entry;
    } vec_t;

    vec_t v[13];

    function automatic logic [24:0] w(input logic [4:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic key(input logic [4:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge Clk);
        key_valid = 1'b0;
    endtask

    task automatic start_game(input logic [24:0] t);
        Start  = 1'b1;
        target = t;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic ack_pulse();
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
    endtask

    task automatic type_word(input logic [24:0] wd);
        for (int i = 0; i < 5; i++) key(wd[5*i +: 5]);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !q_Done; i++) @(negedge Clk);
        chk("done_wait", {31'd0, q_Done}, 32'd1);
    endtask

    localparam logic [24:0] CRANE = 25'({5'd4, 5'd13, 5'd0, 5'd17, 5'd2});
    localparam logic [24:0] APPLE = 25'({5'd4, 5'd11, 5'd15, 5'd15, 5'd0});
    localparam logic [24:0] PAPPY = 25'({5'd24, 5'd15, 5'd15, 5'd0, 5'd15});
    localparam logic [24:0] AAAAA = 25'd0;

    initial begin
        v[0]  = '{5'd27, 3'd0, w(0, 0, 0, 0, 0), 1'b1};
        v[1]  = '{5'd26, 3'd0, w(0, 0, 0, 0, 0), 1'b1};
        v[2]  = '{5'd30, 3'd0, w(0, 0, 0, 0, 0), 1'b1};
        v[3]  = '{5'd2,  3'd1, w(2, 0, 0, 0, 0), 1'b1};
        v[4]  = '{5'd17, 3'd2, w(2, 17, 0, 0, 0), 1'b1};
        v[5]  = '{5'd0,  3'd3, w(2, 17, 0, 0, 0), 1'b1};
        v[6]  = '{5'd27, 3'd3, w(2, 17, 0, 0, 0), 1'b1};
        v[7]  = '{5'd13, 3'd4, w(2, 17, 0, 13, 0), 1'b1};
        v[8]  = '{5'd4,  3'd5, w(2, 17, 0, 13, 4), 1'b1};
        v[9]  = '{5'd25, 3'd5, w(2, 17, 0, 13, 4), 1'b1};
        v[10] = '{5'd26, 3'd4, w(2, 17, 0, 13, 0), 1'b1};
        v[11] = '{5'd31, 3'd4, w(2, 17, 0, 13, 0), 1'b1};
        v[12] = '{5'd4,  3'd5, w(2, 17, 0, 13, 4), 1'b1};

        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("reset_qi", {31'd0, q_I}, 32'd1);
        chk("reset_outs", {guess, guess_len, win, game_over}, 32'd0);
        chk("reset_score", {19'd0, score, guess_num}, 32'd0);

        // entry edges, ending with CRANE typed in full
        start_game(CRANE);
        chk("start_entry", {31'd0, q_Entry}, 32'd1);
        for (int i = 0; i < 13; i++) begin
            key(v[i].code);
            chk($sformatf("vec%0d_len", i), {29'd0, guess_len}, {29'd0, v[i].len});
            chk($sformatf("vec%0d_guess", i), {7'd0, guess}, {7'd0, v[i].g});
            chk($sformatf("vec%0d_entry", i), {31'd0, q_Entry}, {31'd0, v[i].entry});
        end

        // exact match and six-edge latency
        key(5'd27);
        chk("crane_scoring", {31'd0, q_Score}, 32'd1);
        repeat (5) @(negedge Clk);
        chk("crane_not_done_e5", {31'd0, q_Done}, 32'd0);
        @(negedge Clk);
        chk("crane_done_e6", {31'd0, q_Done}, 32'd1);
        chk("crane_score", {22'd0, score}, 32'b1010101010);
        chk("crane_win", {31'd0, win}, 32'd1);
        chk("crane_num", {29'd0, guess_num}, 32'd1);
        ack_pulse();
        chk("crane_ack_qi", {31'd0, q_I}, 32'd1);
        chk("crane_game_over", {31'd0, game_over}, 32'd1);
        chk("crane_guess_kept", {7'd0, guess}, {7'd0, CRANE});

        // duplicates, with key strobes arriving during scoring
        start_game(APPLE);
        chk("apple_go_clear", {31'd0, game_over}, 32'd0);
        type_word(PAPPY);
        key(5'd27);
        for (int i = 0; i < 4; i++) key(5'd7);
        wait_done();
        chk("pappy_score", {22'd0, score}, 32'b0000100101);
        chk("pappy_win", {31'd0, win}, 32'd0);
        chk("pappy_guess", {7'd0, guess}, {7'd0, PAPPY});
        chk("pappy_len", {29'd0, guess_len}, 32'd5);
        chk("pappy_num", {29'd0, guess_num}, 32'd1);
        ack_pulse();
        chk("pappy_ack_entry", {31'd0, q_Entry}, 32'd1);
        chk("pappy_ack_len", {29'd0, guess_len}, 32'd0);
        chk("pappy_ack_clear", {7'd0, guess}, 32'd0);

        // exhaustion: six wrong guesses against CRANE
        ack_pulse();
        chk("stray_ack_entry", {31'd0, q_Entry}, 32'd1);
        @(negedge Clk);
        start_game(APPLE);
        chk("stray_start_entry", {31'd0, q_Entry}, 32'd1);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        start_game(CRANE);
        for (int g = 1; g <= 6; g++) begin
            type_word(AAAAA);
            key(5'd27);
            wait_done();
            chk($sformatf("exh%0d_num", g), {29'd0, guess_num}, g);
            chk($sformatf("exh%0d_score", g), {22'd0, score}, 32'b0000100000);
            ack_pulse();
            chk($sformatf("exh%0d_state", g), {30'd0, q_I, q_Entry}, (g == 6) ? 32'd2 : 32'd1);
        end
        chk("exh_game_over", {31'd0, game_over}, 32'd1);
        chk("exh_win", {31'd0, win}, 32'd0);
        key(5'd3);
        chk("exh_key_ignored", {guess, guess_len, win, game_over, q_I}, {AAAAA, 3'd5, 1'b0, 1'b1, 1'b1});
        chk("exh_key_score", {19'd0, score, guess_num}, {19'd0, 10'b0000100000, 3'd6});

        // reset during QYELLOW idx 2
        start_game(CRANE);
        type_word(CRANE);
        key(5'd27);
        repeat (3) @(negedge Clk);
        chk("mid_scoring", {31'd0, q_Score}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_reset_qi", {28'd0, q_I, q_Entry, q_Score, q_Done}, 32'd8);
        chk("mid_reset_outs", {guess, guess_len, win, game_over}, 32'd0);
        chk("mid_reset_score", {19'd0, score, guess_num}, 32'd0);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        start_game(APPLE);
        type_word(APPLE);
        key(5'd27);
        wait_done();
        chk("post_reset_score", {22'd0, score}, 32'b1010101010);
        chk("post_reset_num", {30'd0, win, guess_num[0]}, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
